// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: in-order dispatch FIFO between decode and the per-FU issue queues.
// Ports: decode handshake (id_*), ROB alloc (rob_*), issue strobes, flush, status.
`ifndef ROB_DEPTH
`define ROB_DEPTH 32
`endif

module dispatch_ctrl #(
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 16,
    parameter int ROB_W     = $clog2(`ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [1:0]       id_fu_class,
    input  logic [ROB_W-1:0] id_alloc_rob,
    output logic             id_ready,
    input  logic             rob_full,
    output logic             rob_alloc_en,
    input  logic [3:0]       queue_full,
    output logic [3:0]       issue2queue_en,
    output logic [ROB_W-1:0] dispatch_rob,
    input  logic             rob_commit_br_taken,
    input  logic             rob_commit_exp_en,
    output logic             buf_empty,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(BUF_DEPTH);

    logic [1:0]       cls_q [BUF_DEPTH];
    logic [ROB_W-1:0] rob_q [BUF_DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W:0]   count;

    logic       flush;
    logic       nonempty;
    logic [1:0] head_cls;
    logic       push;
    logic       pop;
    logic       stall_inc;

    assign flush    = rob_commit_br_taken || rob_commit_exp_en;
    assign nonempty = (count != '0);
    assign head_cls = cls_q[rptr];

    // Ready ignores a same-cycle pop to keep decode's timing path short.
    assign id_ready     = (count != FULL_CNT) && !rob_full && !flush;
    assign push         = id_valid && id_ready;
    assign rob_alloc_en = push;

    always_comb begin
        issue2queue_en = '0;
        if (nonempty && !flush && !queue_full[head_cls])
            issue2queue_en[head_cls] = 1'b1;
    end

    assign pop          = |issue2queue_en;
    assign dispatch_rob = nonempty ? rob_q[rptr] : '0;
    assign buf_empty    = !nonempty;
    assign stall_inc    = nonempty && queue_full[head_cls] && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                cls_q[i] <= '0;
                rob_q[i] <= '0;
            end
        end else if (push) begin
            cls_q[wptr] <= id_fu_class;
            rob_q[wptr] <= id_alloc_rob;
        end
    end

    // Survives flush on purpose: it tracks lifetime head-of-line blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall_inc && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: random and directed stimulus against a queue-based model.
// Checks all outputs every cycle; prints one summary line.
module tb_dispatch_ctrl;

    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int RW    = 5;
    localparam int SMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [1:0]    id_fu_class;
    logic [RW-1:0] id_alloc_rob;
    logic          id_ready;
    logic          rob_full;
    logic          rob_alloc_en;
    logic [3:0]    queue_full;
    logic [3:0]    issue2queue_en;
    logic [RW-1:0] dispatch_rob;
    logic          rob_commit_br_taken;
    logic          rob_commit_exp_en;
    logic          buf_empty;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    dispatch_ctrl #(
        .BUF_DEPTH(DEPTH),
        .CNT_W(CW),
        .ROB_W(RW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .id_valid(id_valid),
        .id_fu_class(id_fu_class),
        .id_alloc_rob(id_alloc_rob),
        .id_ready(id_ready),
        .rob_full(rob_full),
        .rob_alloc_en(rob_alloc_en),
        .queue_full(queue_full),
        .issue2queue_en(issue2queue_en),
        .dispatch_rob(dispatch_rob),
        .rob_commit_br_taken(rob_commit_br_taken),
        .rob_commit_exp_en(rob_commit_exp_en),
        .buf_empty(buf_empty),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        int cls;
        int rob;
    } ent_t;

    ent_t mq[$];
    int   m_stall;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        id_valid = 1'b0;
        rob_full = 1'b0;
        rob_commit_br_taken = 1'b0;
        rob_commit_exp_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_empty", buf_empty, 1);
        check("rst_en", issue2queue_en, 0);
        check("rst_rob", dispatch_rob, 0);
        check("rst_alloc", rob_alloc_en, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_ready", id_ready, 1);
        mq.delete();
        m_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic v, input int cls, input int rob,
                        input logic rf, input logic [3:0] qf,
                        input logic br, input logic ex);
        logic       fl;
        logic       e_ready;
        logic       e_alloc;
        logic [3:0] e_en;
        int         e_rob;
        @(negedge clk);
        id_valid = v;
        id_fu_class = 2'(cls);
        id_alloc_rob = RW'(rob);
        rob_full = rf;
        queue_full = qf;
        rob_commit_br_taken = br;
        rob_commit_exp_en = ex;
        #1;
        fl = br || ex;
        e_ready = (mq.size() < DEPTH) && !rf && !fl;
        e_alloc = v && e_ready;
        e_en = 4'b0;
        e_rob = 0;
        if (mq.size() > 0) begin
            e_rob = mq[0].rob;
            if (!fl && !qf[mq[0].cls])
                e_en = 4'b0001 << mq[0].cls;
        end
        check("ready", id_ready, e_ready);
        check("alloc", rob_alloc_en, e_alloc);
        check("issue_en", issue2queue_en, e_en);
        check("disp_rob", dispatch_rob, e_rob);
        check("empty", buf_empty, mq.size() == 0);
        check("stall", stall_cnt, m_stall);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && qf[mq[0].cls] && m_stall < SMAX)
                m_stall++;
            if (e_en != 4'b0)
                void'(mq.pop_front());
            if (e_alloc)
                mq.push_back('{cls, rob});
        end
    endtask

    task automatic idle(input logic [3:0] qf);
        step(1'b0, 0, 0, 1'b0, qf, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0;
        id_fu_class = 2'd0;
        id_alloc_rob = '0;
        rob_full = 1'b0;
        queue_full = 4'b0;
        rob_commit_br_taken = 1'b0;
        rob_commit_exp_en = 1'b0;
        m_stall = 0;

        do_reset();
        for (int i = 0; i < 4; i++)
            step(1'b1, 0, i, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(4'b0);
        idle(4'b0);

        do_reset();
        step(1'b1, 1, 5, 1'b0, 4'b0010, 1'b0, 1'b0);
        step(1'b1, 0, 6, 1'b0, 4'b0010, 1'b0, 1'b0);
        step(1'b1, 0, 7, 1'b0, 4'b0010, 1'b0, 1'b0);
        idle(4'b0010);
        #1;
        check("stall_three", stall_cnt, 3);
        step(1'b1, 2, 8, 1'b0, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 2, 9, 1'b0, 4'b0000, 1'b0, 1'b0);
        idle(4'b0);
        idle(4'b0);

        step(1'b1, 3, 10, 1'b0, 4'b1111, 1'b0, 1'b0);
        step(1'b1, 1, 11, 1'b0, 4'b1111, 1'b0, 1'b0);
        step(1'b1, 0, 12, 1'b0, 4'b1111, 1'b0, 1'b1);
        idle(4'b0);
        step(1'b1, 0, 13, 1'b0, 4'b0, 1'b1, 1'b0);
        step(1'b1, 2, 14, 1'b1, 4'b0, 1'b0, 1'b0);
        idle(4'b0);

        do_reset();
        for (int i = 0; i < 7; i++)
            step(1'b1, (i * 3) % 4, 20 + i, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(4'b0);
        idle(4'b0);

        step(1'b1, 2, 30, 1'b0, 4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            idle(4'b0100);
        #1;
        check("stall_sat", stall_cnt, SMAX);
        idle(4'b0);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] qf;
            qf[0] = ($urandom_range(0, 3) == 0);
            qf[1] = ($urandom_range(0, 3) == 0);
            qf[2] = ($urandom_range(0, 3) == 0);
            qf[3] = ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 31)),
                 ($urandom_range(0, 7) == 0),
                 qf,
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 31) == 0));
            if (i == 1500)
                do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
